// File: rtl/soda_pkg.sv
// Shared definitions for the soda vending controller: state and credit-op
// encodings, default sizing constants and the flat price-table slice helper.
package soda_pkg;

    localparam int DEF_W       = 8;
    localparam int DEF_NPROD   = 4;
    localparam int DEF_UNIT    = 5;
    localparam int DEF_TIMEOUT = 200;

    // Widest price and widest flat price table the slice helper handles.
    localparam int PRICE_MAXW = 32;
    localparam int TBL_MAXW   = 512;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_REFUND   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_HOLD      = 3'd0,
        OP_ADD       = 3'd1,
        OP_SUB_PRICE = 3'd2,
        OP_SUB_UNIT  = 3'd3,
        OP_CLEAR     = 3'd4
    } credit_op_t;

    // Extract the i_w-bit price of product i_idx from a zero-padded flat table.
    function automatic logic [PRICE_MAXW-1:0] price_slice(
        input logic [TBL_MAXW-1:0] i_tbl,
        input int unsigned         i_idx,
        input int unsigned         i_w
    );
        logic [PRICE_MAXW-1:0] r_res;
        r_res = '0;
        for (int unsigned b = 0; b < PRICE_MAXW; b++) begin
            if ((b < i_w) && ((i_idx * i_w + b) < TBL_MAXW)) begin
                r_res[b] = i_tbl[i_idx * i_w + b];
            end else begin
                r_res[b] = 1'b0;
            end
        end
        return r_res;
    endfunction

endpackage

// File: rtl/soda_credit_dp.sv
// Credit datapath: registered running total with add / subtract-price /
// subtract-unit / clear operations and the compare flags the FSM steers on.
module soda_credit_dp
    import soda_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int UNIT = DEF_UNIT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  credit_op_t   i_op,
    input  logic [W-1:0] i_coin_val,
    input  logic [W-1:0] i_price,
    output logic [W-1:0] o_total,
    output logic         o_ovf,
    output logic         o_ge_price,
    output logic         o_ge_unit
);

    localparam logic [W-1:0] UNIT_W = W'(UNIT);

    logic [W-1:0] r_total;
    logic [W:0]   w_sum;

    // Carry out of the W-bit add flags a coin that would overflow the total.
    assign w_sum      = {1'b0, r_total} + {1'b0, i_coin_val};
    assign o_ovf      = w_sum[W];
    assign o_ge_price = (r_total >= i_price);
    assign o_ge_unit  = (r_total >= UNIT_W);
    assign o_total    = r_total;

    // Total register; every subtract is gated by its compare so it never wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_total <= '0;
        end else begin
            case (i_op)
                OP_ADD: begin
                    if (!o_ovf) begin
                        r_total <= w_sum[W-1:0];
                    end
                end
                OP_SUB_PRICE: begin
                    if (o_ge_price) begin
                        r_total <= r_total - i_price;
                    end
                end
                OP_SUB_UNIT: begin
                    if (o_ge_unit) begin
                        r_total <= r_total - UNIT_W;
                    end
                end
                OP_CLEAR: r_total <= '0;
                default:  r_total <= r_total;
            endcase
        end
    end

endmodule

// File: rtl/soda_vend_controller.sv
// Multi-product vending sequencer: collects coins, dispenses the selected
// product through a req/ack handshake and pays change or refunds in UNIT coins.
module soda_vend_controller
    import soda_pkg::*;
#(
    parameter  int W       = DEF_W,
    parameter  int NPROD   = DEF_NPROD,
    parameter  int UNIT    = DEF_UNIT,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int SW      = (NPROD > 1) ? $clog2(NPROD) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_coin_v,
    input  logic [W-1:0]     i_coin_val,
    input  logic             i_sel_v,
    input  logic [SW-1:0]    i_sel_id,
    input  logic [NPROD*W-1:0] i_price_tbl,
    input  logic             i_cancel,
    input  logic             i_disp_ack,
    output logic             o_disp_req,
    output logic [SW-1:0]    o_disp_id,
    output logic             o_chg_pulse,
    output logic             o_coin_rej,
    output logic             o_busy,
    output logic [W-1:0]     o_total
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t        r_state;
    logic          r_disp_req;
    logic [SW-1:0] r_disp_id;
    logic          r_chg_pulse;
    logic          r_chg_phase;
    logic          r_coin_rej;
    logic          r_busy;
    logic [TW-1:0] r_timer;

    state_t        w_state_nxt;
    credit_op_t    w_op;
    logic          w_rej_nxt;
    logic          w_chg_nxt;
    logic          w_phase_nxt;
    logic          w_req_nxt;
    logic          w_busy_nxt;
    logic [SW-1:0] w_id_nxt;
    logic [TW-1:0] w_timer_nxt;

    logic [TBL_MAXW-1:0] w_tbl_pad;
    logic [W-1:0]        w_price;
    logic                w_sel_ok;
    logic                w_buy_ok;
    logic                w_ovf;
    logic                w_ge_price;
    logic                w_ge_unit;
    logic [W-1:0]        w_total;

    assign w_tbl_pad = TBL_MAXW'(i_price_tbl);
    assign w_price   = W'(price_slice(w_tbl_pad, 32'(i_sel_id), W));
    assign w_sel_ok  = (32'(i_sel_id) < 32'(NPROD));
    assign w_buy_ok  = i_sel_v && w_sel_ok && w_ge_price;

    soda_credit_dp #(
        .W    (W),
        .UNIT (UNIT)
    ) u_credit_dp (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_op       (w_op),
        .i_coin_val (i_coin_val),
        .i_price    (w_price),
        .o_total    (w_total),
        .o_ovf      (w_ovf),
        .o_ge_price (w_ge_price),
        .o_ge_unit  (w_ge_unit)
    );

    // Next-state, datapath op and next output values; cancel > sel_v > coin_v.
    always_comb begin
        w_state_nxt = r_state;
        w_op        = OP_HOLD;
        w_rej_nxt   = 1'b0;
        w_chg_nxt   = 1'b0;
        w_phase_nxt = 1'b0;
        w_req_nxt   = 1'b0;
        w_id_nxt    = r_disp_id;
        w_timer_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_buy_ok) begin
                    // Only a zero-priced product can pass the compare here.
                    w_state_nxt = ST_DISPENSE;
                    w_op        = OP_SUB_PRICE;
                    w_id_nxt    = i_sel_id;
                    w_rej_nxt   = i_coin_v;
                end else if (i_coin_v) begin
                    if (w_ovf) begin
                        w_rej_nxt = 1'b1;
                    end else begin
                        w_op        = OP_ADD;
                        w_state_nxt = ST_COLLECT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (i_cancel || (r_timer == TW'(TIMEOUT))) begin
                    w_state_nxt = ST_REFUND;
                    w_rej_nxt   = i_coin_v;
                end else if (w_buy_ok) begin
                    w_state_nxt = ST_DISPENSE;
                    w_op        = OP_SUB_PRICE;
                    w_id_nxt    = i_sel_id;
                    w_rej_nxt   = i_coin_v;
                end else if (i_coin_v) begin
                    if (w_ovf) begin
                        w_rej_nxt   = 1'b1;
                        w_timer_nxt = r_timer;
                    end else begin
                        w_op        = OP_ADD;
                        w_timer_nxt = '0;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            ST_DISPENSE: begin
                w_rej_nxt = i_coin_v;
                // An ack only counts once the request is actually on the wire.
                if (r_disp_req && i_disp_ack) begin
                    w_state_nxt = ST_CHANGE;
                    w_req_nxt   = 1'b0;
                end else begin
                    w_req_nxt   = 1'b1;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                w_rej_nxt = i_coin_v;
                if (r_chg_phase) begin
                    w_phase_nxt = 1'b0;
                    w_chg_nxt   = 1'b0;
                end else if (w_ge_unit) begin
                    w_phase_nxt = 1'b1;
                    w_chg_nxt   = 1'b1;
                    w_op        = OP_SUB_UNIT;
                end else begin
                    // Residual below one coin is forfeited.
                    w_op        = OP_CLEAR;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_op        = OP_CLEAR;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == ST_DISPENSE) ||
                        (w_state_nxt == ST_CHANGE)   ||
                        (w_state_nxt == ST_REFUND);

    // FSM state, timer, change phase and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_disp_req  <= 1'b0;
            r_disp_id   <= '0;
            r_chg_pulse <= 1'b0;
            r_chg_phase <= 1'b0;
            r_coin_rej  <= 1'b0;
            r_busy      <= 1'b0;
            r_timer     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_disp_req  <= w_req_nxt;
            r_disp_id   <= w_id_nxt;
            r_chg_pulse <= w_chg_nxt;
            r_chg_phase <= w_phase_nxt;
            r_coin_rej  <= w_rej_nxt;
            r_busy      <= w_busy_nxt;
            r_timer     <= w_timer_nxt;
        end
    end

    assign o_disp_req  = r_disp_req;
    assign o_disp_id   = r_disp_id;
    assign o_chg_pulse = r_chg_pulse;
    assign o_coin_rej  = r_coin_rej;
    assign o_busy      = r_busy;
    assign o_total     = w_total;

endmodule

// File: tb/tb_soda_vend_controller.sv
// Directed bench for soda_vend_controller: a vector table for the main flows
// plus hand-written sequences for overflow, timeout and reset mid-change.
module tb_soda_vend_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_v = 1'b0;
    logic [7:0] coin_val = 8'd0;
    logic       sel_v = 1'b0;
    logic [1:0] sel_id = 2'd0;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       disp_req;
    logic [1:0] disp_id;
    logic       chg_pulse;
    logic       coin_rej;
    logic       busy;
    logic [7:0] total;
    // Prices: p0=20, p1=15, p2=25, p3=0.
    logic [31:0] price_tbl = {8'd0, 8'd25, 8'd15, 8'd20};

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    soda_vend_controller dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_coin_v    (coin_v),
        .i_coin_val  (coin_val),
        .i_sel_v     (sel_v),
        .i_sel_id    (sel_id),
        .i_price_tbl (price_tbl),
        .i_cancel    (cancel),
        .i_disp_ack  (disp_ack),
        .o_disp_req  (disp_req),
        .o_disp_id   (disp_id),
        .o_chg_pulse (chg_pulse),
        .o_coin_rej  (coin_rej),
        .o_busy      (busy),
        .o_total     (total)
    );

    typedef struct {
        logic       cv;
        logic [7:0] cval;
        logic       sv;
        logic [1:0] sid;
        logic       cn;
        logic       ak;
        logic       req;
        logic [1:0] id;
        logic       chg;
        logic       rej;
        logic       busy;
        logic [7:0] tot;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input int cv, input int cval, input int sv, input int sid,
                                input int cn, input int ak, input int req, input int id,
                                input int chg, input int rej, input int bz, input int tot);
        vec_t v;
        v.cv = 1'(cv);   v.cval = 8'(cval); v.sv = 1'(sv);   v.sid = 2'(sid);
        v.cn = 1'(cn);   v.ak = 1'(ak);     v.req = 1'(req); v.id = 2'(id);
        v.chg = 1'(chg); v.rej = 1'(rej);   v.busy = 1'(bz); v.tot = 8'(tot);
        return v;
    endfunction

    // Expected return sequence from a given credit: pulse/gap pairs, then IDLE.
    function void push_ret(input int start, input int id);
        int t;
        t = start;
        while (t >= 5) begin
            t = t - 5;
            vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, id, 1, 0, 1, t));
            vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, id, 0, 0, 1, t));
        end
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, id, 0, 0, 0, 0));
    endfunction

    task automatic drive(input int cv, input int cval, input int sv, input int sid,
                         input int cn, input int ak);
        coin_v   = 1'(cv);
        coin_val = 8'(cval);
        sel_v    = 1'(sv);
        sel_id   = 2'(sid);
        cancel   = 1'(cn);
        disp_ack = 1'(ak);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Step until the return engine goes idle, counting change pulses.
    task automatic run_return(input string nm, input int exp_pulses);
        int p;
        p = 0;
        for (int k = 0; k < 400; k++) begin
            idle();
            if (chg_pulse) p++;
            if (!busy) break;
        end
        chk({nm, "_pulses"}, p, exp_pulses);
        chk({nm, "_total"}, int'(total), 0);
        chk({nm, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int first;

        // Reset value, then exact change: 10+10+5 buys product 2 at 25.
        vt.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10));
        vt.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 20));
        vt.push_back(mk(1, 5, 0, 0, 0, 0,  0, 0, 0, 0, 0, 25));
        vt.push_back(mk(0, 0, 1, 2, 0, 0,  0, 2, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 2, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 2, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 1,  0, 2, 0, 0, 1, 0));
        push_ret(0, 2);
        // Change return 35-15=20 -> 4 pulses; a coin during DISPENSE is rejected.
        vt.push_back(mk(1, 25, 0, 0, 0, 0, 0, 2, 0, 0, 0, 25));
        vt.push_back(mk(1, 10, 0, 0, 0, 0, 0, 2, 0, 0, 0, 35));
        vt.push_back(mk(0, 0, 1, 1, 0, 0,  0, 1, 0, 0, 1, 20));
        vt.push_back(mk(1, 5, 0, 0, 0, 0,  1, 1, 0, 1, 1, 20));
        vt.push_back(mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 1, 20));
        push_ret(20, 1);
        // Insufficient credit ignored, then enough credit dispenses product 0.
        vt.push_back(mk(1, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 10));
        vt.push_back(mk(0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 10));
        vt.push_back(mk(1, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 20));
        vt.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0));
        push_ret(0, 0);
        // Cancel with 17: three pulses, 2 forfeited.
        vt.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10));
        vt.push_back(mk(1, 5, 0, 0, 0, 0,  0, 0, 0, 0, 0, 15));
        vt.push_back(mk(1, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 17));
        vt.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 17));
        push_ret(17, 0);
        // Cancel and select together: refund wins, product id not latched.
        vt.push_back(mk(1, 25, 0, 0, 0, 0, 0, 0, 0, 0, 0, 25));
        vt.push_back(mk(0, 0, 1, 2, 1, 0,  0, 0, 0, 0, 1, 25));
        push_ret(25, 0);
        // Zero-priced product 3 dispenses straight from IDLE.
        vt.push_back(mk(0, 0, 1, 3, 0, 0,  0, 3, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 3, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 1,  0, 3, 0, 0, 1, 0));
        push_ret(0, 3);

        // Synchronous reset, checked while asserted.
        idle();
        idle();
        chk("reset_busy", int'(busy), 0);
        chk("reset_total", int'(total), 0);
        chk("reset_req", int'(disp_req), 0);
        rst = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].cv, vt[i].cval, vt[i].sv, vt[i].sid, vt[i].cn, vt[i].ak);
            n_vec++;
            if ({disp_req, disp_id, chg_pulse, coin_rej, busy, total} !=
                {vt[i].req, vt[i].id, vt[i].chg, vt[i].rej, vt[i].busy, vt[i].tot}) begin
                n_miss++;
                $display("FAIL vec%0d: got req=%b id=%0d chg=%b rej=%b busy=%b total=%0d, expected req=%b id=%0d chg=%b rej=%b busy=%b total=%0d",
                         i, disp_req, disp_id, chg_pulse, coin_rej, busy, total,
                         vt[i].req, vt[i].id, vt[i].chg, vt[i].rej, vt[i].busy, vt[i].tot);
            end
        end

        // Overflow: 250 + 10 would exceed 255, coin rejected and total held.
        drive(1, 250, 0, 0, 0, 0);
        chk("ovf_load", int'(total), 250);
        drive(1, 10, 0, 0, 0, 0);
        chk("ovf_rej", int'(coin_rej), 1);
        chk("ovf_hold", int'(total), 250);
        drive(0, 0, 0, 0, 1, 0);
        chk("ovf_refund_busy", int'(busy), 1);
        run_return("ovf_refund", 50);

        // Inactivity timeout: refund starts after 200 idle cycles counted.
        drive(1, 10, 0, 0, 0, 0);
        chk("tmo_load", int'(total), 10);
        first = -1;
        for (int k = 1; k <= 260; k++) begin
            idle();
            if (busy) begin
                first = k;
                break;
            end
        end
        chk("tmo_cycle", first, 201);
        run_return("tmo_refund", 2);

        // Reset after the first change pulse aborts with no further return.
        drive(1, 25, 0, 0, 0, 0);
        drive(1, 5, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0);
        chk("rstchg_sub", int'(total), 15);
        idle();
        chk("rstchg_req", int'(disp_req), 1);
        drive(0, 0, 0, 0, 0, 1);
        idle();
        chk("rstchg_pulse1", int'(chg_pulse), 1);
        chk("rstchg_total1", int'(total), 10);
        rst = 1'b1;
        idle();
        chk("rstchg_total", int'(total), 0);
        chk("rstchg_outs", int'({disp_req, disp_id, chg_pulse, coin_rej, busy}), 0);
        rst = 1'b0;
        idle();
        chk("rstchg_stay_idle", int'({chg_pulse, busy, total}), 0);
        drive(1, 5, 0, 0, 0, 0);
        chk("rstchg_recover", int'(total), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
